// File: rtl/sram_ctrl_pkg.sv
// Shared geometry, sleep-FSM state type and port request bundle for the
// 512x64 two-port SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_AW   = 9;
  localparam int SRAM_DW   = 64;
  localparam int SRAM_NB   = 8;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } slp_state_e;

  typedef struct packed {
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_NB-1:0] be;
    logic [SRAM_DW-1:0] wdata;
  } port_req_t;

  // Byte enables fan out to one mask bit per data bit.
  function automatic logic [SRAM_DW-1:0] be2bw(input logic [SRAM_NB-1:0] be);
    logic [SRAM_DW-1:0] bw;
    bw = '0;
    for (int k = 0; k < SRAM_NB; k++) bw[k*8 +: 8] = {8{be[k]}};
    return bw;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; priority flips to the loser after
// every grant and starts at port 0.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic prio_q;

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
        default: gnt_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     prio_q <= 1'b0;
    else if (|gnt_o) prio_q <= gnt_o[0];
  end

endmodule

// File: rtl/sram512x64_arb.sv
// Core/DMA arbiter in front of a 512x64 dual-address SRAM macro, with an
// idle-driven deep-sleep FSM and a fixed one-cycle response pipe.
module sram512x64_arb
  import sram_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS-1:0][SRAM_AW-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0][SRAM_NB-1:0]   be_i,
  input  logic [NUM_PORTS-1:0][SRAM_DW-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [SRAM_DW-1:0]                  rdata_o,
  output logic                                sram_cena_o,
  output logic                                sram_cenb_o,
  output logic [SRAM_AW-1:0]                  sram_aa_o,
  output logic [SRAM_AW-1:0]                  sram_ab_o,
  output logic [SRAM_DW-1:0]                  sram_d_o,
  output logic [SRAM_DW-1:0]                  sram_bw_o,
  input  logic [SRAM_DW-1:0]                  sram_q_i,
  output logic                                sram_deepsleep_o,
  output logic                                sram_powergate_o,
  output logic                                sleeping_o
);

  localparam int ICW    = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int STAGES = 1;
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_CYCLES);
  localparam logic [3:0]     WAKE_LAST = 4'(WAKE_CYCLES - 1);

  port_req_t [NUM_PORTS-1:0] preq;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pack
    assign preq[p] = {we_i[p], addr_i[p], be_i[p], wdata_i[p]};
  end

  slp_state_e     state_q, state_d;
  logic [ICW-1:0] idle_q, idle_d;
  logic [3:0]     wake_q, wake_d;
  logic           sleep_q;
  logic           any_req, active;

  assign any_req = |req_i;
  // Gate on rst_ni too so no grant leaks out while reset is held.
  assign active  = (state_q == ST_ACTIVE) & rst_ni;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ST_ACTIVE: begin
        if (any_req) begin
          idle_d = '0;
        end else begin
          if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
          // A request in this cycle takes the other branch and keeps ACTIVE.
          if (IDLE_CYCLES > 0 && idle_d == IDLE_MAX) state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (any_req) begin
          state_d = ST_WAKE;
          wake_d  = '0;
        end
      end
      ST_WAKE: begin
        if (wake_q == WAKE_LAST) begin
          state_d = ST_ACTIVE;
          idle_d  = '0;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
      sleep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
      sleep_q <= (state_d == ST_SLEEP);
    end
  end

  assign sram_deepsleep_o = sleep_q;
  assign sleeping_o       = sleep_q;
  assign sram_powergate_o = 1'b0;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (active),
    .req_i  (req_i),
    .gnt_o  (gnt_o)
  );

  logic      g_any;
  port_req_t sel;
  assign g_any = |gnt_o;
  assign sel   = preq[gnt_o[1]];

  assign sram_cena_o = ~(g_any & ~sel.we);
  assign sram_cenb_o = ~(g_any &  sel.we);
  assign sram_aa_o   = sel.addr;
  assign sram_ab_o   = sel.addr;
  assign sram_d_o    = sel.wdata;
  assign sram_bw_o   = (g_any & sel.we) ? be2bw(sel.be) : '0;

  // Response valid trails the grant by the macro's read latency.
  logic [STAGES:1][NUM_PORTS-1:0] vld_pipe;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= gnt_o;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign rvalid_o = vld_pipe[STAGES];
  assign rdata_o  = sram_q_i;

endmodule
